// File: rtl/load_store_unit_if.sv
// Bundle of the pipeline-side and data-memory-side signals of the load/store unit.
//
// Handshakes:
//   pipeline side: the pipeline raises ex_valid with mem_op/addr/wdata and must hold
//     all four stable while stall=1; the operation is complete in the cycle done=1,
//     which is also the first cycle with stall=0.
//   memory side: dm_req stays high with dm_addr/dm_we/dm_wstrb/dm_wdata stable until
//     the cycle in which dm_ack=1; dm_rdata is only meaningful in that cycle.
// The slave modport is the load/store unit's view; master is the surrounding system.
interface load_store_unit_if;
    logic        ex_valid;
    logic [4:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dataout;
    logic        done;
    logic        stall;
    logic        misalign_exc;
    logic        bus_err;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport slave (
        input  ex_valid, mem_op, addr, wdata, dm_ack, dm_rdata,
        output dataout, done, stall, misalign_exc, bus_err,
               dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata
    );

    modport master (
        output ex_valid, mem_op, addr, wdata, dm_ack, dm_rdata,
        input  dataout, done, stall, misalign_exc, bus_err,
               dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns one pipeline memory instruction into one data-memory
// request, with byte/half/word strobes, lane-replicated store data, a shifted
// load result, and a bus-error timeout while waiting for dm_ack.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   - misaligned half/word accesses issue no request and finish with
//               misalign_exc=1 alongside done.
//   undefined - misaligned low address bits are masked to the access size and the
//               access proceeds; misalign_exc stays 0.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_e          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      off_q;
    logic            load_q;

    logic            is_load;
    logic            is_store;
    logic            is_access;
    logic            misaligned;
    logic            trap_c;
    logic            accept;
    logic [1:0]      off_c;
    logic [3:0]      strb_c;
    logic [31:0]     wdata_c;

    // Decode the presented instruction: access type, alignment, lanes and strobes.
    always_comb begin
        is_load    = (bus.mem_op[4:3] == 2'b01);
        is_store   = (bus.mem_op[4:3] == 2'b10);
        is_access  = (is_load || is_store) && (bus.mem_op[1:0] != 2'b11);
        misaligned = 1'b0;
        off_c      = 2'b00;
        strb_c     = 4'b0000;
        wdata_c    = bus.wdata;
        case (bus.mem_op[1:0])
            2'b00: begin
                off_c   = bus.addr[1:0];
                strb_c  = 4'b0001 << bus.addr[1:0];
                wdata_c = {4{bus.wdata[7:0]}};
            end
            2'b01: begin
                misaligned = bus.addr[0];
                off_c      = {bus.addr[1], 1'b0};
                strb_c     = 4'b0011 << {bus.addr[1], 1'b0};
                wdata_c    = {2{bus.wdata[15:0]}};
            end
            2'b10: begin
                misaligned = |bus.addr[1:0];
                off_c      = 2'b00;
                strb_c     = 4'b1111;
                wdata_c    = bus.wdata;
            end
            default: begin
                misaligned = 1'b0;
            end
        endcase
        if (!is_store) begin
            strb_c = 4'b0000;
        end
        trap_c = TRAP_EN && misaligned;
        accept = (state == IDLE) && bus.ex_valid && is_access;
    end

    // Stall is combinational in the accepting IDLE cycle and held through ACCESS.
    always_comb begin
        bus.stall = !rst && (accept || (state == ACCESS));
    end

    // Main FSM: registers the request fields, waits for ack or timeout, pulses done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            off_q            <= 2'b00;
            load_q           <= 1'b0;
            bus.dataout      <= 32'h0;
            bus.done         <= 1'b0;
            bus.misalign_exc <= 1'b0;
            bus.bus_err      <= 1'b0;
            bus.dm_req       <= 1'b0;
            bus.dm_we        <= 1'b0;
            bus.dm_addr      <= 32'h0;
            bus.dm_wstrb     <= 4'b0000;
            bus.dm_wdata     <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done         <= 1'b0;
                    bus.misalign_exc <= 1'b0;
                    bus.bus_err      <= 1'b0;
                    if (accept) begin
                        if (trap_c) begin
                            state            <= DONE;
                            bus.done         <= 1'b1;
                            bus.misalign_exc <= 1'b1;
                            bus.dataout      <= 32'h0;
                        end else begin
                            state        <= ACCESS;
                            cnt          <= '0;
                            off_q        <= off_c;
                            load_q       <= is_load;
                            bus.dm_req   <= 1'b1;
                            bus.dm_we    <= is_store;
                            bus.dm_addr  <= {bus.addr[31:2], 2'b00};
                            bus.dm_wstrb <= strb_c;
                            bus.dm_wdata <= wdata_c;
                        end
                    end
                end
                ACCESS: begin
                    cnt <= cnt + CW'(1);
                    if (bus.dm_ack) begin
                        state        <= DONE;
                        bus.done     <= 1'b1;
                        bus.dm_req   <= 1'b0;
                        bus.dm_we    <= 1'b0;
                        bus.dm_wstrb <= 4'b0000;
                        bus.dataout  <= load_q ? (bus.dm_rdata >> {off_q, 3'b000}) : 32'h0;
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        state        <= DONE;
                        bus.done     <= 1'b1;
                        bus.bus_err  <= 1'b1;
                        bus.dm_req   <= 1'b0;
                        bus.dm_we    <= 1'b0;
                        bus.dm_wstrb <= 4'b0000;
                        bus.dataout  <= 32'h0;
                    end
                end
                DONE: begin
                    state            <= IDLE;
                    bus.done         <= 1'b0;
                    bus.misalign_exc <= 1'b0;
                    bus.bus_err      <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Expose the FSM state for observation.
    always_comb begin
        state_dbg = state;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against a byte-level reference model.
module tb_load_store_unit;

    localparam int T = 4;

    logic        clk;
    logic        rst;
    logic [1:0]  state_dbg;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        bit          acc;
        bit          we;
        logic [31:0] daddr;
        logic [3:0]  strb;
        logic [31:0] dwd;
        logic [31:0] dout;
        bit          berr;
        bit          mexc;
        int          lat;
        int          nreq;
    } exp_t;

    // Reference model: byte lanes computed arithmetically from size and offset.
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] rd,
                                   input int ack_at);
        exp_t e;
        int nb;
        int off;
        e = '{default: 0};
        e.acc = ((op[4:3] == 2'b01) || (op[4:3] == 2'b10)) && (op[1:0] != 2'b11);
        if (!e.acc) return e;
        nb   = 1 << op[1:0];
        off  = int'(a[1:0]);
        e.we = (op[4:3] == 2'b10);
`ifdef MISALIGN_TRAP_EN
        if ((off % nb) != 0) begin
            e.mexc = 1;
            e.lat  = 1;
            e.nreq = 0;
            e.dout = 32'h0;
            return e;
        end
`endif
        off     = off - (off % nb);
        e.daddr = a & 32'hFFFF_FFFC;
        for (int i = 0; i < 4; i++) begin
            e.strb[i]       = e.we && (i >= off) && (i < off + nb);
            e.dwd[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
        if (ack_at >= 1 && ack_at <= T) begin
            e.lat  = ack_at + 1;
            e.nreq = ack_at;
            e.dout = e.we ? 32'h0 : (rd >> (8 * off));
        end else begin
            e.lat  = T + 1;
            e.nreq = T;
            e.berr = 1;
            e.dout = 32'h0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Driver: issue one instruction, act as memory acking in ACCESS cycle ack_at (0 = never).
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int ack_at);
        exp_t e;
        int n;
        int nreq;
        bit seen;
        logic [31:0] exp_dout;
        e = model(op, a, wd, rd, ack_at);
        @(posedge clk); #1;
        bus.ex_valid = 1'b1;
        bus.mem_op   = op;
        bus.addr     = a;
        bus.wdata    = wd;
        bus.dm_ack   = 1'b0;
        #1;
        chk("issue_stall", 32'(bus.stall), 32'(e.acc));
        chk("issue_req", 32'(bus.dm_req), 32'h0);
        if (!e.acc) begin
            @(posedge clk); #1;
            chk("noacc_done", 32'(bus.done), 32'h0);
            chk("noacc_req", 32'(bus.dm_req), 32'h0);
            bus.ex_valid = 1'b0;
            return;
        end
        exp_q.push_back(e.dout);
        n = 1;
        nreq = 0;
        seen = 0;
        while (n <= T + 3) begin
            @(posedge clk); #1;
            if (bus.done) begin
                seen = 1;
                break;
            end
            chk("acc_req", 32'(bus.dm_req), 32'h1);
            chk("acc_stall", 32'(bus.stall), 32'h1);
            chk("acc_addr", bus.dm_addr, e.daddr);
            chk("acc_we", 32'(bus.dm_we), 32'(e.we));
            chk("acc_strb", 32'(bus.dm_wstrb), 32'(e.strb));
            if (e.we) chk("acc_wdata", bus.dm_wdata, e.dwd);
            nreq++;
            bus.dm_ack   = (n == ack_at);
            bus.dm_rdata = (n == ack_at) ? rd : $urandom;
            n++;
        end
        bus.dm_ack = 1'b0;
        chk("done_seen", 32'(seen), 32'h1);
        chk("latency", 32'(n), 32'(e.lat));
        chk("req_cycles", 32'(nreq), 32'(e.nreq));
        exp_dout = exp_q.pop_front();
        if (seen) begin
            chk("done_stall", 32'(bus.stall), 32'h0);
            chk("done_req", 32'(bus.dm_req), 32'h0);
            chk("dataout", bus.dataout, exp_dout);
            chk("bus_err", 32'(bus.bus_err), 32'(e.berr));
            chk("misalign_exc", 32'(bus.misalign_exc), 32'(e.mexc));
        end
        bus.ex_valid = 1'b0;
        @(posedge clk); #1;
        chk("done_pulse", 32'(bus.done), 32'h0);
        chk("idle_stall", 32'(bus.stall), 32'h0);
    endtask

    initial begin
        logic [4:0] op;
        rst          = 1'b1;
        bus.ex_valid = 1'b0;
        bus.mem_op   = 5'h0;
        bus.addr     = 32'h0;
        bus.wdata    = 32'h0;
        bus.dm_ack   = 1'b0;
        bus.dm_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_dataout", bus.dataout, 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_stall", 32'(bus.stall), 32'h0);
        chk("rst_mexc", 32'(bus.misalign_exc), 32'h0);
        chk("rst_berr", 32'(bus.bus_err), 32'h0);
        chk("rst_req", 32'(bus.dm_req), 32'h0);
        chk("rst_we", 32'(bus.dm_we), 32'h0);
        chk("rst_strb", 32'(bus.dm_wstrb), 32'h0);
        chk("rst_addr", bus.dm_addr, 32'h0);
        chk("rst_wdata", bus.dm_wdata, 32'h0);
        chk("rst_state", 32'(state_dbg), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Load word 0x100, ack in first ACCESS cycle
        run_op(5'b01010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1);
        // Load byte 0x103
        run_op(5'b01000, 32'h0000_0103, 32'h0, 32'hAB00_0000, 1);
        // Store half 0x202
        run_op(5'b10001, 32'h0000_0202, 32'h0000_1234, 32'h0, 2);
        // Misaligned load word 0x101
        run_op(5'b01010, 32'h0000_0101, 32'h0, 32'h1122_3344, 1);
        // Misaligned store half 0x203
        run_op(5'b10001, 32'h0000_0203, 32'h0000_ABCD, 32'h0, 1);
        // Timeout with no ack, then ack on the last allowed cycle
        run_op(5'b01010, 32'h0000_0400, 32'h0, 32'h5555_5555, 0);
        run_op(5'b01010, 32'h0000_0400, 32'h0, 32'h5555_5555, T);
        // No-access encodings
        run_op(5'b01011, 32'h0000_0100, 32'h0, 32'h0, 1);
        run_op(5'b00010, 32'h0000_0100, 32'h0, 32'h0, 1);
        run_op(5'b11010, 32'h0000_0100, 32'h0, 32'h0, 1);

        // ex_valid low with a valid op: nothing happens
        @(posedge clk); #1;
        bus.mem_op = 5'b01010;
        bus.addr   = 32'h0000_0800;
        #1;
        chk("novalid_stall", 32'(bus.stall), 32'h0);
        @(posedge clk); #1;
        chk("novalid_req", 32'(bus.dm_req), 32'h0);

        // Reset pulse in the middle of ACCESS
        @(posedge clk); #1;
        bus.ex_valid = 1'b1;
        bus.mem_op   = 5'b10010;
        bus.addr     = 32'h0000_0300;
        bus.wdata    = 32'hCAFE_F00D;
        @(posedge clk); #1;
        chk("mid_req_before", 32'(bus.dm_req), 32'h1);
        #2;
        rst          = 1'b1;
        bus.ex_valid = 1'b0;
        #1;
        chk("mid_req_after", 32'(bus.dm_req), 32'h0);
        chk("mid_stall", 32'(bus.stall), 32'h0);
        chk("mid_addr", bus.dm_addr, 32'h0);
        chk("mid_state", 32'(state_dbg), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("mid_no_done", 32'(bus.done), 32'h0);
            chk("mid_no_req", 32'(bus.dm_req), 32'h0);
        end
        run_op(5'b01010, 32'h0000_0300, 32'h0, 32'h0BAD_F00D, 1);

        // Randomized instructions
        for (int i = 0; i < 60; i++) begin
            op = 5'($urandom);
            if ($urandom_range(0, 3) != 0) op[4:3] = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
            run_op(op, $urandom, $urandom, $urandom, $urandom_range(1, T + 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
